// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter in front of the single-port data memory
//
// Purpose: grants at most one of two masters per cycle to dmem. Port 0 (processor)
//    has fixed priority; port 1 (loader/debug) is forced to win once it has been
//    denied MAX_WAIT consecutive cycles. Read data returns one cycle after the grant
//    with a per-port valid strobe.
// Ports:
//    clock, reset             - single clock, synchronous active-high reset
//    mX_req/wren/addr/data    - master X request, write flag, address, write data
//    mX_gnt                   - master X granted this cycle (combinational)
//    mX_rvalid, mX_q          - master X read data valid (registered) and data
//    mem_address/data/wren    - drive to dmem
//    mem_q                    - dmem read data (one cycle after the address)
//    conflict_cnt             - saturating count of cycles with both requests
module dmem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_wren,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_data,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_q,
   input  logic              m1_req,
   input  logic              m1_wren,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_data,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_q,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q,
   output logic [15:0]       conflict_cnt
);

   localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

   logic [3:0]  r_wait1;
   logic        r_m0_rvalid;
   logic        r_m1_rvalid;
   logic [15:0] r_conflict_cnt;

   logic        w_force1;
   logic        w_m0_gnt;
   logic        w_m1_gnt;

   // Port 1 wins when alone, or when contending after MAX_WAIT denied cycles.
   // Port 0 takes whatever port 1 does not; reset suppresses both so no write lands.
   assign w_force1 = (r_wait1 == LP_MAX_WAIT);
   assign w_m1_gnt = ~reset & m1_req & (~m0_req | w_force1);
   assign w_m0_gnt = ~reset & m0_req & ~w_m1_gnt;

   assign m0_gnt = w_m0_gnt;
   assign m1_gnt = w_m1_gnt;

   // With no grant the bus idles on port 0's inputs, so it is never X.
   assign mem_address = w_m1_gnt ? m1_addr : m0_addr;
   assign mem_data    = w_m1_gnt ? m1_data : m0_data;
   assign mem_wren    = (w_m0_gnt & m0_wren) | (w_m1_gnt & m1_wren);

   // The RAM output already lags the address by one cycle, which lines up with rvalid.
   assign m0_q = mem_q;
   assign m1_q = mem_q;

   assign m0_rvalid    = r_m0_rvalid;
   assign m1_rvalid    = r_m1_rvalid;
   assign conflict_cnt = r_conflict_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wait1        <= 4'd0;
         r_m0_rvalid    <= 1'b0;
         r_m1_rvalid    <= 1'b0;
         r_conflict_cnt <= 16'd0;
      end else begin
         r_m0_rvalid <= w_m0_gnt & ~m0_wren;
         r_m1_rvalid <= w_m1_gnt & ~m1_wren;

         // Counts consecutive denied cycles of a pending port 1 request.
         if (w_m1_gnt || !m1_req) begin
            r_wait1 <= 4'd0;
         end else if (r_wait1 != LP_MAX_WAIT) begin
            r_wait1 <= r_wait1 + 4'd1;
         end

         if (m0_req && m1_req && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   localparam int MAXW = 4;

   logic        clock;
   logic        reset;
   logic        m0_req, m0_wren, m1_req, m1_wren;
   logic [11:0] m0_addr, m1_addr;
   logic [31:0] m0_data, m1_data;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_q, m1_q;
   logic [11:0] mem_address;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic [31:0] mem_q;
   logic [15:0] conflict_cnt;

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
      .clock(clock), .reset(reset),
      .m0_req(m0_req), .m0_wren(m0_wren), .m0_addr(m0_addr), .m0_data(m0_data),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_q(m0_q),
      .m1_req(m1_req), .m1_wren(m1_wren), .m1_addr(m1_addr), .m1_data(m1_data),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_q(m1_q),
      .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
      .mem_q(mem_q), .conflict_cnt(conflict_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] init_val(input int i);
      return (32'(i) * 32'h0001_0001) ^ 32'hC3A5_0000;
   endfunction

   // Synchronous single-port RAM standing in for dmem.
   logic [31:0] ram [0:4095];
   logic        do_init;
   always @(posedge clock) begin
      if (do_init) begin
         for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
      end else if (mem_wren) begin
         ram[mem_address] <= mem_data;
      end
      mem_q <= ram[mem_address];
   end

   // Reference model state
   logic [31:0] ref_mem [0:4095];
   int          exp_wait;
   int          exp_cnt;
   logic        exp_rv0, exp_rv1;
   logic [31:0] exp_q;
   logic        regs_known;
   logic        last_g0, last_g1;

   int n_checks;
   int n_pass;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [11:0] a1, input logic [31:0] d1);
      m0_req = r0; m0_wren = w0; m0_addr = a0; m0_data = d0;
      m1_req = r1; m1_wren = w1; m1_addr = a1; m1_data = d1;
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
   endtask

   // Compare the settled cycle against the model, then advance one clock.
   task automatic step();
      logic g0, g1, ew;
      logic [11:0] ea;
      logic [31:0] ed;
      if (reset) begin
         g0 = 1'b0; g1 = 1'b0;
      end else if (m0_req && m1_req) begin
         g1 = (exp_wait >= MAXW);
         g0 = !g1;
      end else begin
         g0 = m0_req; g1 = m1_req;
      end
      ew = (g0 && m0_wren) || (g1 && m1_wren);
      ea = g1 ? m1_addr : m0_addr;
      ed = g1 ? m1_data : m0_data;
      chk("m0_gnt", m0_gnt, g0);
      chk("m1_gnt", m1_gnt, g1);
      chk("mem_wren", mem_wren, ew);
      chk("mem_address", mem_address, ea);
      chk("mem_data", mem_data, ed);
      if (regs_known) begin
         chk("m0_rvalid", m0_rvalid, exp_rv0);
         chk("m1_rvalid", m1_rvalid, exp_rv1);
         chk("conflict_cnt", conflict_cnt, exp_cnt[15:0]);
         if (exp_rv0) chk("m0_q", m0_q, exp_q);
         if (exp_rv1) chk("m1_q", m1_q, exp_q);
      end
      last_g0 = g0;
      last_g1 = g1;
      @(posedge clock);
      if (reset) begin
         exp_wait = 0; exp_cnt = 0; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
         regs_known = 1'b1;
      end else begin
         exp_rv0 = g0 && !m0_wren;
         exp_rv1 = g1 && !m1_wren;
         if (exp_rv0 || exp_rv1) exp_q = ref_mem[ea];
         if (ew) ref_mem[ea] = ed;
         if (m1_req && !g1) exp_wait = (exp_wait < MAXW) ? exp_wait + 1 : MAXW;
         else exp_wait = 0;
         if (m0_req && m1_req && exp_cnt < 65535) exp_cnt++;
      end
      @(negedge clock);
   endtask

   initial begin
      logic nr0, nw0, nr1, nw1;
      logic [11:0] na0, na1;
      logic [31:0] nd0, nd1;
      n_checks = 0; n_pass = 0;
      exp_wait = 0; exp_cnt = 0; exp_rv0 = 0; exp_rv1 = 0; exp_q = '0;
      regs_known = 1'b0; last_g0 = 0; last_g1 = 0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);

      // Reset for 2 cycles, then 10 idle cycles
      reset = 1'b1; do_init = 1'b1;
      idle(); step();
      idle(); step();
      do_init = 1'b0; reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         idle();
         chk("idle_wren", mem_wren, 1'b0);
         step();
      end
      chk("idle_cnt", conflict_cnt, 16'd0);

      // Port 0 write then read back
      drive(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, 12'h0, 32'h0);
      chk("p0_wr_gnt", m0_gnt, 1'b1);
      chk("p0_wr_wren", mem_wren, 1'b1);
      step();
      drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
      step();
      idle();
      chk("p0_rd_rvalid", m0_rvalid, 1'b1);
      chk("p0_rd_q", m0_q, 32'hDEADBEEF);
      step();

      // Port 1 back-to-back reads of 0..3
      for (int i = 0; i < 5; i++) begin
         if (i < 4) drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'(i), 32'h0);
         else idle();
         if (i > 0) begin
            chk("p1_b2b_rvalid", m1_rvalid, 1'b1);
            chk("p1_b2b_q", m1_q, init_val(i - 1));
         end
         step();
      end
      idle(); step();

      // Starvation bound: m0 continuous, m1 read 0x020 from cycle 0
      for (int c = 0; c < 6; c++) begin
         drive(1'b1, 1'b0, 12'h005, 32'h0, (c < 5), 1'b0, 12'h020, 32'h0);
         if (c < 5) chk("starve_m1_gnt", m1_gnt, (c == 4));
         if (c == 4) chk("starve_m0_gnt", m0_gnt, 1'b0);
         if (c == 5) begin
            chk("starve_m1_rvalid", m1_rvalid, 1'b1);
            chk("starve_m1_q", m1_q, init_val(32'h020));
            chk("starve_cnt", conflict_cnt, 16'd5);
         end
         step();
      end
      idle(); step();

      // Contention: both write 0x030, m0 wins first, m1 next
      drive(1'b1, 1'b1, 12'h030, 32'h1, 1'b1, 1'b1, 12'h030, 32'h2);
      chk("cont_m0_first", m0_gnt, 1'b1);
      step();
      drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 12'h030, 32'h2);
      chk("cont_m1_second", m1_gnt, 1'b1);
      step();
      drive(1'b1, 1'b0, 12'h030, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
      step();
      idle();
      chk("cont_rd_q", m0_q, 32'h2);
      step();

      // Reset mid-read, with a port 0 write attempted during reset
      drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h040, 32'h0);
      step();
      reset = 1'b1;
      drive(1'b1, 1'b1, 12'h040, 32'h12345678, 1'b0, 1'b0, 12'h0, 32'h0);
      chk("rst_m0_gnt", m0_gnt, 1'b0);
      chk("rst_wren", mem_wren, 1'b0);
      step();
      reset = 1'b0;
      idle();
      chk("rst_m1_rvalid", m1_rvalid, 1'b0);
      step();
      // wait1 restarted: port 1 forced in again only after MAXW denials
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, 1'b0, 12'h040, 32'h0, 1'b1, 1'b0, 12'h041, 32'h0);
         chk("rst_wait_m1_gnt", m1_gnt, (c == 4));
         step();
      end
      drive(1'b1, 1'b0, 12'h040, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
      step();
      idle();
      chk("rst_mem_kept", m0_q, init_val(32'h040));
      step();

      // Randomized traffic obeying the hold-until-granted contract
      nr0 = 0; nw0 = 0; na0 = '0; nd0 = '0;
      nr1 = 0; nw1 = 0; na1 = '0; nd1 = '0;
      for (int k = 0; k < 400; k++) begin
         reset = ($urandom_range(0, 49) == 0);
         if (!(nr0 && !last_g0)) begin
            nr0 = ($urandom_range(0, 99) < 70);
            nw0 = $urandom_range(0, 1);
            na0 = 12'h100 + 12'($urandom_range(0, 7));
            nd0 = $urandom;
         end
         if (!(nr1 && !last_g1)) begin
            nr1 = ($urandom_range(0, 99) < 60);
            nw1 = $urandom_range(0, 1);
            na1 = 12'h100 + 12'($urandom_range(0, 7));
            nd1 = $urandom;
         end
         drive(nr0, nw0, na0, nd0, nr1, nw1, na1, nd1);
         step();
      end
      reset = 1'b0;
      idle(); step();
      idle(); step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
